// File: rtl/wb_snoop_responder.sv
// Snoop sequencer for one data cache: shares the cache's single tag/data
// array port between the CPU load/store path and snoop read lookups coming
// from the Wishbone snoop arbiter, and bounds how long snoops may hold off
// a waiting CPU request.
module wb_snoop_responder #(
  parameter int dw         = 32,
  parameter int aw         = 32,
  parameter int line_bits  = 4,
  parameter int max_streak = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [aw-1:0] snoop_adr_i,
  input  logic          snoop_type_i,
  input  logic          snoop_self_i,
  output logic          snoop_ack_o,
  output logic          snoop_hit_o,
  output logic [dw-1:0] snoop_dat_o,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [aw-1:0] cpu_adr_i,
  input  logic [dw-1:0] cpu_dat_i,
  output logic          cpu_gnt_o,
  output logic          arr_en_o,
  output logic          arr_we_o,
  output logic [aw-1:0] arr_adr_o,
  output logic [dw-1:0] arr_dat_o,
  input  logic [dw-1:0] arr_rdat_i,
  input  logic          arr_hit_i
);

  localparam int sw = $clog2(max_streak + 1);
  localparam int lw = aw - line_bits;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } state_t;

  state_t         state_q, state_d;
  logic [sw-1:0]  streak_q, streak_d;
  logic [lw-1:0]  snoop_line_q;
  logic           ack_q;
  logic           hit_q;
  logic [dw-1:0]  dat_q;

  logic           streak_full;
  logic           snoop_pend;
  logic           take_snoop;
  logic           cpu_blocked;

  assign streak_full = (streak_q == sw'(max_streak));
  assign snoop_pend  = snoop_type_i & ~snoop_self_i & (state_q == IDLE);
  assign take_snoop  = snoop_pend & ~(cpu_req_i & streak_full);
  assign cpu_blocked = cpu_we_i & (cpu_adr_i[aw-1:line_bits] == snoop_line_q);

  assign snoop_ack_o = ack_q;
  assign snoop_hit_o = hit_q;
  assign snoop_dat_o = dat_q;

  // Array port steering, CPU grant, and next state / streak; everything is forced low while reset is held.
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    cpu_gnt_o = 1'b0;
    arr_en_o  = 1'b0;
    arr_we_o  = 1'b0;
    arr_adr_o = cpu_adr_i;
    arr_dat_o = cpu_dat_i;
    case (state_q)
      IDLE: begin
        if (take_snoop) begin
          arr_en_o  = 1'b1;
          arr_adr_o = snoop_adr_i;
          state_d   = LOOKUP;
          if (cpu_req_i && !streak_full) begin
            streak_d = streak_q + 1'b1;
          end
        end else begin
          cpu_gnt_o = cpu_req_i;
          arr_en_o  = cpu_req_i;
          arr_we_o  = cpu_we_i;
          if (cpu_req_i) begin
            streak_d = '0;
          end
        end
      end
      LOOKUP: begin
        state_d = RESP;
      end
      RESP: begin
        cpu_gnt_o = cpu_req_i & ~cpu_blocked;
        arr_en_o  = cpu_req_i & ~cpu_blocked;
        arr_we_o  = cpu_req_i & ~cpu_blocked & cpu_we_i;
        if (!snoop_type_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!wb_rst_ni) begin
      cpu_gnt_o = 1'b0;
      arr_en_o  = 1'b0;
      arr_we_o  = 1'b0;
      arr_adr_o = '0;
      arr_dat_o = '0;
    end
  end

  // State, streak counter and the captured snoop line.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      streak_q     <= '0;
      snoop_line_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      if (take_snoop) begin
        snoop_line_q <= snoop_adr_i[aw-1:line_bits];
      end
    end
  end

  // Snoop response: captured from the array after the lookup, held until the arbiter drops the request.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      hit_q <= 1'b0;
      dat_q <= '0;
    end else begin
      case (state_q)
        LOOKUP: begin
          ack_q <= 1'b1;
          hit_q <= arr_hit_i;
          dat_q <= arr_hit_i ? arr_rdat_i : '0;
        end
        RESP: begin
          if (!snoop_type_i) begin
            ack_q <= 1'b0;
            hit_q <= 1'b0;
            dat_q <= '0;
          end
        end
        default: begin
          ack_q <= ack_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_snoop_responder.sv
// Bench for wb_snoop_responder: directed snoop/CPU sequences with a
// behavioural model compared on every falling edge, plus literal checks.
module tb_wb_snoop_responder;

  localparam int MAX_STREAK = 4;
  localparam int LINE_BITS  = 4;

  logic        wb_clk_i;
  logic        wb_rst_ni;
  logic [31:0] snoop_adr_i;
  logic        snoop_type_i;
  logic        snoop_self_i;
  logic        snoop_ack_o;
  logic        snoop_hit_o;
  logic [31:0] snoop_dat_o;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [31:0] cpu_adr_i;
  logic [31:0] cpu_dat_i;
  logic        cpu_gnt_o;
  logic        arr_en_o;
  logic        arr_we_o;
  logic [31:0] arr_adr_o;
  logic [31:0] arr_dat_o;
  logic [31:0] arr_rdat_i;
  logic        arr_hit_i;

  int n_checks = 0;
  int n_pass   = 0;

  wb_snoop_responder #(
    .dw(32), .aw(32), .line_bits(LINE_BITS), .max_streak(MAX_STREAK)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .snoop_adr_i (snoop_adr_i),
    .snoop_type_i(snoop_type_i),
    .snoop_self_i(snoop_self_i),
    .snoop_ack_o (snoop_ack_o),
    .snoop_hit_o (snoop_hit_o),
    .snoop_dat_o (snoop_dat_o),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_adr_i   (cpu_adr_i),
    .cpu_dat_i   (cpu_dat_i),
    .cpu_gnt_o   (cpu_gnt_o),
    .arr_en_o    (arr_en_o),
    .arr_we_o    (arr_we_o),
    .arr_adr_o   (arr_adr_o),
    .arr_dat_o   (arr_dat_o),
    .arr_rdat_i  (arr_rdat_i),
    .arr_hit_i   (arr_hit_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus, driven just after the rising edge; returns just after the falling edge.
  task automatic applyStimulus(input logic typ, input logic slf, input logic [31:0] sadr,
                               input logic req, input logic we, input logic [31:0] cadr,
                               input logic [31:0] cdat, input logic ahit, input logic [31:0] rdat);
    @(posedge wb_clk_i);
    #1;
    snoop_type_i = typ;
    snoop_self_i = slf;
    snoop_adr_i  = sadr;
    cpu_req_i    = req;
    cpu_we_i     = we;
    cpu_adr_i    = cadr;
    cpu_dat_i    = cdat;
    arr_hit_i    = ahit;
    arr_rdat_i   = rdat;
    @(negedge wb_clk_i);
    #1;
  endtask

  // Model of the responder: a snoop in flight with its age in cycles since acceptance,
  // the captured line, the response it will present, and how many contests the CPU has lost in a row.
  logic        m_busy = 1'b0;
  int          m_age  = 0;
  logic [27:0] m_line = '0;
  logic        m_ack  = 1'b0;
  logic        m_hit  = 1'b0;
  logic [31:0] m_dat  = '0;
  int          m_lost = 0;

  always @(negedge wb_clk_i) begin : model_compare
    logic        e_gnt, e_en, e_we, wins;
    logic [31:0] e_adr;
    if (!wb_rst_ni) begin
      checkOutput("rst_ack", {63'd0, snoop_ack_o}, 64'd0);
      checkOutput("rst_hit", {63'd0, snoop_hit_o}, 64'd0);
      checkOutput("rst_dat", {32'd0, snoop_dat_o}, 64'd0);
      checkOutput("rst_gnt", {63'd0, cpu_gnt_o}, 64'd0);
      checkOutput("rst_en",  {63'd0, arr_en_o}, 64'd0);
      checkOutput("rst_we",  {63'd0, arr_we_o}, 64'd0);
      m_busy = 1'b0; m_age = 0; m_line = '0;
      m_ack = 1'b0; m_hit = 1'b0; m_dat = '0; m_lost = 0;
    end else begin
      wins  = 1'b0;
      e_gnt = 1'b0; e_en = 1'b0; e_we = 1'b0; e_adr = cpu_adr_i;
      if (!m_busy) begin
        wins = snoop_type_i && !snoop_self_i && !(cpu_req_i && m_lost >= MAX_STREAK);
        if (wins) begin
          e_en = 1'b1; e_adr = snoop_adr_i;
        end else begin
          e_gnt = cpu_req_i; e_en = cpu_req_i; e_we = cpu_we_i;
        end
      end else if (m_age >= 2) begin
        e_gnt = cpu_req_i && !(cpu_we_i && (cpu_adr_i >> LINE_BITS) == {4'd0, m_line});
        e_en  = e_gnt;
        e_we  = e_gnt && cpu_we_i;
      end
      checkOutput("model_gnt", {63'd0, cpu_gnt_o}, {63'd0, e_gnt});
      checkOutput("model_en",  {63'd0, arr_en_o}, {63'd0, e_en});
      checkOutput("model_ack", {63'd0, snoop_ack_o}, {63'd0, m_ack});
      checkOutput("model_hit", {63'd0, snoop_hit_o}, {63'd0, m_hit});
      checkOutput("model_dat", {32'd0, snoop_dat_o}, {32'd0, m_dat});
      if (e_en) begin
        checkOutput("model_we",  {63'd0, arr_we_o}, {63'd0, e_we});
        checkOutput("model_adr", {32'd0, arr_adr_o}, {32'd0, e_adr});
        if (e_we) checkOutput("model_wdat", {32'd0, arr_dat_o}, {32'd0, cpu_dat_i});
      end
      if (!m_busy) begin
        if (wins) begin
          m_busy = 1'b1; m_age = 1; m_line = snoop_adr_i[31:4];
          if (cpu_req_i) m_lost = (m_lost + 1 > MAX_STREAK) ? MAX_STREAK : m_lost + 1;
        end else if (cpu_req_i) begin
          m_lost = 0;
        end
      end else if (m_age == 1) begin
        m_ack = 1'b1; m_hit = arr_hit_i; m_dat = arr_hit_i ? arr_rdat_i : 32'd0;
        m_age = 2;
      end else if (!snoop_type_i) begin
        m_busy = 1'b0; m_age = 0;
        m_ack = 1'b0; m_hit = 1'b0; m_dat = '0;
      end
    end
  end

  // Directed sequences with hand-computed literal expectations.
  initial begin
    wb_rst_ni    = 1'b0;
    snoop_type_i = 1'b0; snoop_self_i = 1'b0; snoop_adr_i = '0;
    cpu_req_i    = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 32'h40; cpu_dat_i = '0;
    arr_hit_i    = 1'b0; arr_rdat_i = '0;
    #3;
    checkOutput("reset_ack", {63'd0, snoop_ack_o}, 64'd0);
    checkOutput("reset_gnt", {63'd0, cpu_gnt_o}, 64'd0);
    checkOutput("reset_en",  {63'd0, arr_en_o}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb_rst_ni = 1'b1;

    // Snoop hit on line 0x100 with line-conflict CPU writes during the response.
    applyStimulus(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("hit_c0_en",  {63'd0, arr_en_o}, 64'd1);
    checkOutput("hit_c0_adr", {32'd0, arr_adr_o}, 64'h100);
    applyStimulus(1, 0, 32'h999, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    checkOutput("hit_c1_ack", {63'd0, snoop_ack_o}, 64'd0);
    applyStimulus(1, 0, 32'h999, 1, 1, 32'h104, 32'h11, 0, 0);
    checkOutput("hit_c2_ack", {63'd0, snoop_ack_o}, 64'd1);
    checkOutput("hit_c2_hit", {63'd0, snoop_hit_o}, 64'd1);
    checkOutput("hit_c2_dat", {32'd0, snoop_dat_o}, 64'hDEADBEEF);
    checkOutput("wr_same_line_gnt", {63'd0, cpu_gnt_o}, 64'd0);
    applyStimulus(1, 0, 32'h999, 1, 1, 32'h110, 32'h22, 0, 0);
    checkOutput("wr_other_line_gnt", {63'd0, cpu_gnt_o}, 64'd1);
    checkOutput("hit_c3_dat", {32'd0, snoop_dat_o}, 64'hDEADBEEF);
    applyStimulus(0, 0, 0, 1, 0, 32'h104, 0, 0, 0);
    checkOutput("rd_same_line_gnt", {63'd0, cpu_gnt_o}, 64'd1);
    checkOutput("hit_c4_ack", {63'd0, snoop_ack_o}, 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hit_c5_ack", {63'd0, snoop_ack_o}, 64'd0);

    // Snoop miss, then a CPU read granted immediately.
    applyStimulus(1, 0, 32'h200, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h200, 0, 0, 0, 0, 0, 32'h1234);
    applyStimulus(1, 0, 32'h200, 0, 0, 0, 0, 0, 0);
    checkOutput("miss_ack", {63'd0, snoop_ack_o}, 64'd1);
    checkOutput("miss_hit", {63'd0, snoop_hit_o}, 64'd0);
    checkOutput("miss_dat", {32'd0, snoop_dat_o}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 32'h300, 0, 0, 0);
    checkOutput("after_miss_gnt", {63'd0, cpu_gnt_o}, 64'd1);
    checkOutput("after_miss_adr", {32'd0, arr_adr_o}, 64'h300);

    // Continuous CPU demand against back-to-back snoops.
    for (int rep = 0; rep < 2; rep++) begin
      for (int g = 0; g < MAX_STREAK; g++) begin
        applyStimulus(1, 0, 32'h800 + 32'(g) * 32'h20, 1, 0, 32'h40, 0, 0, 0);
        checkOutput("streak_snoop_gnt", {63'd0, cpu_gnt_o}, 64'd0);
        applyStimulus(1, 0, 32'h0, 1, 0, 32'h40, 0, 1, 32'hC0DE0000 + 32'(g));
        applyStimulus(1, 0, 32'h0, 1, 0, 32'h40, 0, 0, 0);
        checkOutput("streak_resp_dat", {32'd0, snoop_dat_o}, {32'd0, 32'hC0DE0000 + 32'(g)});
        applyStimulus(0, 0, 32'h0, 1, 0, 32'h40, 0, 0, 0);
      end
      applyStimulus(1, 0, 32'hF00, 1, 0, 32'h40, 0, 0, 0);
      checkOutput("streak_cpu_wins_gnt", {63'd0, cpu_gnt_o}, 64'd1);
      checkOutput("streak_cpu_wins_adr", {32'd0, arr_adr_o}, 64'h40);
    end

    // Own-CPU snoop: CPU path only, never acknowledged.
    applyStimulus(1, 1, 32'h500, 1, 1, 32'h504, 32'hA5A5, 0, 0);
    checkOutput("self_gnt", {63'd0, cpu_gnt_o}, 64'd1);
    checkOutput("self_adr", {32'd0, arr_adr_o}, 64'h504);
    applyStimulus(1, 1, 32'h500, 0, 0, 32'h504, 0, 1, 0);
    checkOutput("self_en", {63'd0, arr_en_o}, 64'd0);
    applyStimulus(1, 1, 32'h500, 0, 0, 32'h504, 0, 1, 0);
    checkOutput("self_ack", {63'd0, snoop_ack_o}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Request dropped during the lookup: one-cycle ack pulse.
    applyStimulus(1, 0, 32'hC00, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 32'hC00, 0, 0, 0, 0, 1, 32'h77);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("drop_pulse_ack", {63'd0, snoop_ack_o}, 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("drop_after_ack", {63'd0, snoop_ack_o}, 64'd0);

    // Reset while presenting a response.
    applyStimulus(1, 0, 32'h900, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h900, 0, 0, 0, 0, 1, 32'h55AA55AA);
    applyStimulus(1, 0, 32'h900, 1, 0, 32'h40, 0, 0, 0);
    checkOutput("pre_rst_ack", {63'd0, snoop_ack_o}, 64'd1);
    checkOutput("pre_rst_gnt", {63'd0, cpu_gnt_o}, 64'd1);
    wb_rst_ni = 1'b0;
    #1;
    checkOutput("async_rst_ack", {63'd0, snoop_ack_o}, 64'd0);
    checkOutput("async_rst_hit", {63'd0, snoop_hit_o}, 64'd0);
    checkOutput("async_rst_dat", {32'd0, snoop_dat_o}, 64'd0);
    checkOutput("async_rst_gnt", {63'd0, cpu_gnt_o}, 64'd0);
    checkOutput("async_rst_en",  {63'd0, arr_en_o}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb_rst_ni = 1'b1;

    // Reset during the lookup, then a fresh snoop with normal latency.
    applyStimulus(1, 0, 32'hA00, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'hA00, 1, 0, 32'h40, 0, 1, 32'h1);
    wb_rst_ni = 1'b0;
    #1;
    checkOutput("lookup_rst_ack", {63'd0, snoop_ack_o}, 64'd0);
    checkOutput("lookup_rst_en",  {63'd0, arr_en_o}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb_rst_ni = 1'b1;
    applyStimulus(1, 0, 32'hB00, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_en",  {63'd0, arr_en_o}, 64'd1);
    checkOutput("post_rst_adr", {32'd0, arr_adr_o}, 64'hB00);
    applyStimulus(1, 0, 32'hB00, 0, 0, 0, 0, 1, 32'h13579BDF);
    checkOutput("post_rst_c1_ack", {63'd0, snoop_ack_o}, 64'd0);
    applyStimulus(1, 0, 32'hB00, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_ack", {63'd0, snoop_ack_o}, 64'd1);
    checkOutput("post_rst_dat", {32'd0, snoop_dat_o}, 64'h13579BDF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_end_ack", {63'd0, snoop_ack_o}, 64'd0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
